// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD adder.
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_ADJ = 4'd6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ADD   = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic digit_invalid(input logic [DIGIT_W-1:0] d);
    return d > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Combinational single-digit BCD adder: binary add, compare against 9, +6 correction.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       ci_i,
  output logic [3:0] s_o,
  output logic       co_o
);

  // 9+9+1 = 19 is the largest possible value, so 5 bits never overflow.
  logic [4:0] s5;
  assign s5 = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, ci_i};

  always_comb begin
    s_o  = s5[3:0];
    co_o = 1'b0;
    if (s5 > {1'b0, BCD_MAX}) begin
      s_o  = s5[3:0] + BCD_ADJ;
      co_o = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial NDIG-digit packed-BCD adder controller sharing one digit adder stage.
// Optional invalid-digit CHECK state enabled by defining BCD_ERR_CHECK_EN.
module bcd_serial_adder_ctrl
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [4*NDIG-1:0]     a_i,
  input  logic [4*NDIG-1:0]     b_i,
  input  logic                  cin_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*NDIG-1:0]     sum_o,
  output logic                  cout_o,
  output logic                  err_o
);

  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);
  localparam int W = DIGIT_W * NDIG;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, done_q;

  logic [DIGIT_W-1:0] dig_a, dig_b, dig_s;
  logic               dig_co;

  // Digit index times DIGIT_W (=4) is a two-bit shift.
  assign dig_a = a_q[{idx_q, 2'b00} +: DIGIT_W];
  assign dig_b = b_q[{idx_q, 2'b00} +: DIGIT_W];

  bcd_digit_adder u_digit (
    .a_i  (dig_a),
    .b_i  (dig_b),
    .ci_i (carry_q),
    .s_o  (dig_s),
    .co_o (dig_co)
  );

`ifdef BCD_ERR_CHECK_EN
  logic [NDIG-1:0] bad_vec;
  logic            err_q, err_d;

  for (genvar gi = 0; gi < NDIG; gi++) begin : g_chk
    assign bad_vec[gi] = digit_invalid(a_q[gi*DIGIT_W +: DIGIT_W]) |
                         digit_invalid(b_q[gi*DIGIT_W +: DIGIT_W]);
  end
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef BCD_ERR_CHECK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          carry_d = cin_i;
          sum_d   = '0;
          cout_d  = 1'b0;
          idx_d   = '0;
`ifdef BCD_ERR_CHECK_EN
          err_d   = 1'b0;
          state_d = CHECK;
`else
          state_d = ADD;
`endif
        end
      end
      CHECK: begin
`ifdef BCD_ERR_CHECK_EN
        if (|bad_vec) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = ADD;
        end
`else
        state_d = IDLE;
`endif
      end
      ADD: begin
        sum_d[{idx_q, 2'b00} +: DIGIT_W] = dig_s;
        carry_d = dig_co;
        if (idx_q == IDX_LAST) begin
          cout_d  = dig_co;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up with state_q.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= (state_d == CHECK) || (state_d == ADD);
      done_q  <= (state_d == DONE);
    end
  end

`ifdef BCD_ERR_CHECK_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Directed self-checking bench for bcd_serial_adder_ctrl (NDIG=4 and NDIG=1 instances).
module tb_bcd_serial_adder_ctrl;

`ifdef BCD_ERR_CHECK_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif
  localparam int NDIG = 4;
  localparam int LAT  = FEAT ? NDIG + 2 : NDIG + 1;
  localparam int LAT1 = FEAT ? 3 : 2;
  localparam int PER  = LAT + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        cin = 1'b0;
  logic        busy, done, cout, err;
  logic [15:0] sum;

  logic        start1 = 1'b0;
  logic [3:0]  a1 = '0, b1 = '0;
  logic        cin1 = 1'b0;
  logic        busy1, done1, cout1, err1;
  logic [3:0]  sum1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bcd_serial_adder_ctrl #(.NDIG(NDIG)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .a_i(a), .b_i(b), .cin_i(cin),
    .busy_o(busy), .done_o(done), .sum_o(sum), .cout_o(cout), .err_o(err)
  );

  bcd_serial_adder_ctrl #(.NDIG(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .a_i(a1), .b_i(b1), .cin_i(cin1),
    .busy_o(busy1), .done_o(done1), .sum_o(sum1), .cout_o(cout1), .err_o(err1)
  );

  // Launch one operation and return the cycle of the done pulse and the busy cycle count.
  task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic c,
                       output int dcyc, output int bcyc);
    int cyc;
    @(negedge clk);
    a = av; b = bv; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 16'hFFFF; b = 16'hEEEE; cin = ~c;
    cyc = 1; bcyc = 0; dcyc = -1;
    while (cyc < 40) begin
      if (done) begin
        dcyc = cyc;
        break;
      end
      if (busy) bcyc++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_vec++;
    if ({sum, cout, err, done, busy} !== 20'h0) begin
      n_err++;
      $display("FAIL reset_state: got sum=%h cout=%b err=%b done=%b busy=%b, want all 0",
               sum, cout, err, done, busy);
    end
    n_vec++;
    if ({sum1, cout1, err1, done1, busy1} !== 8'h0) begin
      n_err++;
      $display("FAIL reset_state_n1: got sum=%h cout=%b err=%b, want all 0", sum1, cout1, err1);
    end
    rst = 1'b0;
    $display("reset released");
  endtask

  task automatic test_basic;
    int dc, bc;
    do_op(16'h1234, 16'h5678, 1'b0, dc, bc);
    $display("op 1234+5678+0: done_cyc=%0d busy=%0d sum=%h cout=%b err=%b", dc, bc, sum, cout, err);
    n_vec++;
    if (dc !== LAT) begin n_err++; $display("FAIL basic_latency: got %0d want %0d", dc, LAT); end
    n_vec++;
    if (bc !== LAT - 1) begin n_err++; $display("FAIL basic_busy: got %0d want %0d", bc, LAT - 1); end
    n_vec++;
    if (sum !== 16'h6912 || cout !== 1'b0 || err !== 1'b0) begin
      n_err++;
      $display("FAIL basic_result: got sum=%h cout=%b err=%b want 6912/0/0", sum, cout, err);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_width: done=%b want 0", done); end
  endtask

  task automatic test_carry;
    int dc, bc;
    logic [15:0] av [3] = '{16'h9999, 16'h9999, 16'h0000};
    logic [15:0] bv [3] = '{16'h0001, 16'h9999, 16'h0000};
    logic        cv [3] = '{1'b0, 1'b1, 1'b1};
    logic [15:0] es [3] = '{16'h0000, 16'h9999, 16'h0001};
    logic        ec [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      do_op(av[i], bv[i], cv[i], dc, bc);
      $display("op %h+%h+%b: done_cyc=%0d sum=%h cout=%b", av[i], bv[i], cv[i], dc, sum, cout);
      n_vec++;
      if (dc !== LAT || sum !== es[i] || cout !== ec[i]) begin
        n_err++;
        $display("FAIL carry_%0d: got cyc=%0d sum=%h cout=%b want cyc=%0d sum=%h cout=%b",
                 i, dc, sum, cout, LAT, es[i], ec[i]);
      end
    end
  endtask

  task automatic test_invalid;
    int dc, bc;
    int          e_cyc  = FEAT ? 2 : NDIG + 1;
    logic [15:0] e_sum  = FEAT ? 16'h0000 : 16'h1304;
    logic        e_err  = FEAT;
    do_op(16'h12A4, 16'h0000, 1'b0, dc, bc);
    $display("op 12A4+0000+0: done_cyc=%0d sum=%h cout=%b err=%b", dc, sum, cout, err);
    n_vec++;
    if (dc !== e_cyc) begin n_err++; $display("FAIL invalid_latency: got %0d want %0d", dc, e_cyc); end
    n_vec++;
    if (sum !== e_sum || cout !== 1'b0 || err !== e_err) begin
      n_err++;
      $display("FAIL invalid_result: got sum=%h cout=%b err=%b want %h/0/%b", sum, cout, err, e_sum, e_err);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (sum !== e_sum || err !== e_err || done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL invalid_hold: got sum=%h err=%b done=%b busy=%b want %h/%b/0/0",
               sum, err, done, busy, e_sum, e_err);
    end
  endtask

  task automatic test_back_to_back;
    int pulses = 0;
    @(negedge clk);
    start = 1'b1; cin = 1'b0;
    for (int c = 0; c < 3 * PER + LAT + 1; c++) begin
      if (c > 0) begin
        n_vec++;
        if (done !== (c % PER == LAT)) begin
          n_err++;
          $display("FAIL b2b_done_c%0d: got %b want %b", c, done, (c % PER == LAT));
        end
        if (done) begin
          pulses++;
          n_vec++;
          if (sum !== 16'h3333 || cout !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_sum_c%0d: got sum=%h cout=%b want 3333/0", c, sum, cout);
          end
          $display("b2b pulse %0d at cycle %0d sum=%h", pulses, c, sum);
        end
      end
      if (c % PER == 0) begin
        a = 16'h1111; b = 16'h2222;
      end else begin
        a = 16'($urandom); b = 16'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_vec++;
    if (pulses !== 4) begin n_err++; $display("FAIL b2b_pulse_count: got %0d want 4", pulses); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int dc, bc;
    bit saw_done = 1'b0;
    @(negedge clk);
    a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({sum, cout, err, done, busy} !== 20'h0) begin
      n_err++;
      $display("FAIL reset_async: got sum=%h cout=%b err=%b done=%b busy=%b want all 0",
               sum, cout, err, done, busy);
    end
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    n_vec++;
    if (saw_done !== 1'b0) begin n_err++; $display("FAIL reset_no_done: got 1 want 0"); end
    do_op(16'h0005, 16'h0005, 1'b0, dc, bc);
    $display("op 0005+0005+0 after reset: done_cyc=%0d sum=%h cout=%b", dc, sum, cout);
    n_vec++;
    if (dc !== LAT || sum !== 16'h0010 || cout !== 1'b0) begin
      n_err++;
      $display("FAIL reset_restart: got cyc=%0d sum=%h cout=%b want %0d/0010/0", dc, sum, cout, LAT);
    end
  endtask

  task automatic test_ndig1;
    int cyc = 1;
    int dc = -1;
    @(negedge clk);
    a1 = 4'h8; b1 = 4'h7; cin1 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; a1 = 4'h0; b1 = 4'h0;
    while (cyc < 20) begin
      if (done1) begin dc = cyc; break; end
      @(negedge clk);
      cyc++;
    end
    $display("op n1 8+7+1: done_cyc=%0d sum=%h cout=%b", dc, sum1, cout1);
    n_vec++;
    if (dc !== LAT1) begin n_err++; $display("FAIL ndig1_latency: got %0d want %0d", dc, LAT1); end
    n_vec++;
    if (sum1 !== 4'h6 || cout1 !== 1'b1 || err1 !== 1'b0) begin
      n_err++;
      $display("FAIL ndig1_result: got sum=%h cout=%b err=%b want 6/1/0", sum1, cout1, err1);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_carry;
    test_invalid;
    test_back_to_back;
    test_reset_mid;
    test_ndig1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_serial_adder_ctrl.md
Name: bcd_serial_adder_ctrl

Overview:
Digit-serial controller that adds two NDIG-digit packed-BCD operands. It time-shares one combinational single-digit BCD adder stage, which computes a binary sum, compares it against 9 and applies the +6 correction. The controller iterates that stage from the least-significant digit upward and holds a registered carry between digits. It sits between the switch/key front end and the 7-segment display decoders and replaces the per-digit ripple adder chain for wide operands.

Parameters:
NDIG, 4, number of BCD digits per operand (1..8)

Ports:
Clock  input  1  system clock, rising-edge
Reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  4*NDIG  operand A, packed BCD, digit 0 = bits [3:0]
b  input  4*NDIG  operand B, packed BCD
cin  input  1  carry-in to digit 0
busy  output  1  high in CHECK and ADD
done  output  1  one-cycle pulse, high in DONE
sum  output  4*NDIG  BCD result; valid from DONE until next accepted start
cout  output  1  decimal carry out of the top digit
err  output  1  invalid-digit flag for the last operation

Behaviour:
- Clock is a single clock. Reset is asynchronous and active-high. While Reset=1: state=IDLE; sum=0, cout=0, err=0, done=0, busy=0; digit index=0; operand registers=0.
- States: IDLE, CHECK, ADD, DONE.
- IDLE: if start=1, capture a, b and cin into registers, clear sum/cout/err, set digit index=0, then go to CHECK. If BCD_ERR_CHECK_EN is undefined, go directly to ADD. Otherwise stay in IDLE.
- start is ignored in CHECK, ADD and DONE. It is never queued. Operand inputs are don't-care after capture.
- CHECK (1 cycle): if any captured digit of A or B is >9, set err=1, leave sum=0 and cout=0, and go to DONE. Otherwise go to ADD.
- ADD (NDIG cycles, one digit per cycle, index i = 0..NDIG-1):
  - s5 = A[i] + B[i] + carry, computed as a 5-bit binary sum.
  - If s5 > 9: digit = (s5 + 6) mod 16 and carry' = 1. Otherwise digit = s5[3:0] and carry' = 0.
  - sum[i] <= digit; carry <= carry'.
  - At i = NDIG-1, cout <= carry', then go to DONE. Otherwise i <= i+1.
- DONE (1 cycle): done=1, busy=0, then go to IDLE. A start during DONE is ignored.
- Latency, with start high in cycle 0:
  - Feature on: CHECK in cycle 1, ADD in cycles 2..NDIG+1, done in cycle NDIG+2.
  - Feature off: done in cycle NDIG+1.
  - Error path: done in cycle 2.
- Outputs are registered. sum, cout and err hold their values through IDLE until the next accepted start.
- Reset mid-operation aborts immediately with no done pulse. The first start after reset release is accepted normally.
- Worst case, 9+9+1 = 19, gives digit 9 with carry 1. The 5-bit sum never overflows.

Optional Feature:
- Macro: BCD_ERR_CHECK_EN.
- Defined: the CHECK state exists and invalid digits (values 10..15) abort with err=1 as described.
- Undefined: the CHECK state is not built. err is tied to 0. Invalid digits pass through the same arithmetic unflagged; the result is unspecified but deterministic per the ADD rule. Latency is one cycle shorter.

Decomposition:
- Shared package bcd_pkg holds:
  - state enum (IDLE, CHECK, ADD, DONE), 2 bits;
  - BCD_MAX = 4'd9;
  - BCD_ADJ = 4'd6;
  - DIGIT_W = 4.
- One sub-module, bcd_digit_adder: purely combinational; inputs a[3:0], b[3:0], ci; outputs s[3:0], co; performs the >9 compare and +6 correction.
- The controller holds the FSM, digit index, carry register and sum register, and selects the operand digits with indexed part-selects.

Test Plan:
- NDIG=4, feature on: a=16'h1234, b=16'h5678, cin=0, start in cycle 0 -> busy cycles 1..5, done=1 in cycle 6, sum=16'h6912, cout=0, err=0.
- a=16'h9999, b=16'h0001, cin=0 -> sum=16'h0000, cout=1; then a=16'h9999, b=16'h9999, cin=1 -> sum=16'h9999, cout=1.
- a=16'h12A4, b=16'h0000 -> err=1, done in cycle 2, sum=0, cout=0. With the feature off: no CHECK, done in cycle 5, err=0.
- start held high continuously -> ops accepted only in IDLE; done pulses exactly every NDIG+3 cycles, each pulse one cycle wide. Changing a/b while busy does not alter the result.
- Reset asserted in cycle 3 (mid-ADD) -> outputs 0 asynchronously, no done pulse. Next start with a=16'h0005, b=16'h0005 -> sum=16'h0010, cout=0.
- NDIG=1: a=4'h8, b=4'h7, cin=1 -> sum=4'h6, cout=1, done in cycle 3.
